sync_fifo_flags: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Uses all DEPTH entries via extended pointers.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) mode, and overflow/underflow reporting.
- Sits between producer/consumer blocks in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_ram.sv | 24 ++
 rtl/sync_fifo_flags.sv | 97 +++++++++
 tb/tb_sync_fifo_flags.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the sync_fifo_flags FIFO.
//   fifo_mode_e : read mode, FIFO_STD (registered dout) or FIFO_FWFT (head word on dout)
//   ptr_w()     : pointer width for a given depth, one extra bit to tell full from empty
package sync_fifo_pkg;
   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH register array, synchronous write, asynchronous read.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module sync_fifo_ram #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags, FWFT mode and error reporting.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   wen/din      : write request and data
//   ren          : read request (pop acknowledge in FIFO_FWFT)
//   clr_err      : clears sticky error flags (only with SYNC_FIFO_ERR_STICKY_EN)
//   dout         : read data
//   full/empty, almost_full/almost_empty, count : status from the registered pointers
//   overflow/underflow : rejected write/read; 1-cycle pulse by default,
//                        sticky until clr_err when SYNC_FIFO_ERR_STICKY_EN is defined
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int         DEPTH    = 8,
   parameter int         WIDTH    = 64,
   parameter fifo_mode_e MODE     = FIFO_STD,
   parameter int         AF_LEVEL = DEPTH - 2,
   parameter int         AE_LEVEL = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wen,
   input  logic [WIDTH-1:0]         din,
   input  logic                     ren,
   input  logic                     clr_err,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic             ov_q, ov_d, uf_q, uf_d;
   logic             we, re;
   logic [WIDTH-1:0] rdata;
   // The extra pointer bit makes the modulo difference span 0..DEPTH.
   assign count        = wr_q - rd_q;
   assign full         = count == PW'(DEPTH);
   assign empty        = count == '0;
   assign almost_full  = count >= PW'(AF_LEVEL);
   assign almost_empty = count <= PW'(AE_LEVEL);
   assign we           = wen && !full;
   assign re           = ren && !empty;
   assign overflow     = ov_q;
   assign underflow    = uf_q;
   always_comb begin
      wr_d = wr_q + PW'(we);
      rd_d = rd_q + PW'(re);
`ifdef SYNC_FIFO_ERR_STICKY_EN
      ov_d = clr_err ? 1'b0 : ov_q | (wen && full);
      uf_d = clr_err ? 1'b0 : uf_q | (ren && empty);
`else
      ov_d = wen && full;
      uf_d = ren && empty;
`endif
   end
`ifndef SYNC_FIFO_ERR_STICKY_EN
   logic unused_clr_err;
   assign unused_clr_err = clr_err;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
         ov_q <= 1'b0;
         uf_q <= 1'b0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         ov_q <= ov_d;
         uf_q <= uf_d;
      end
   sync_fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wr_q[AW-1:0]),
      .wdata_i (din),
      .raddr_i (rd_q[AW-1:0]),
      .rdata_o (rdata)
   );
   if (MODE == FIFO_STD) begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;
      assign dout_d = re ? rdata : dout_q;
      always_ff @(posedge clk or negedge reset)
         if (!reset) dout_q <= '0;
         else dout_q <= dout_d;
      assign dout = dout_q;
   end else begin : g_fwft
      // Head word is exposed directly; storage behind an empty FIFO is stale, so force zero.
      assign dout = empty ? '0 : rdata;
   end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed bench for sync_fifo_flags, one FIFO_STD and one FIFO_FWFT instance.
module tb_sync_fifo_flags;
   import sync_fifo_pkg::*;
   logic        clk = 0, reset = 1, clr_err = 0;
   logic        s_wen = 0, s_ren = 0, f_wen = 0, f_ren = 0;
   logic [63:0] s_din = 0, f_din = 0, s_dout, f_dout;
   logic        s_full, s_empty, s_af, s_ae, s_ov, s_uf;
   logic        f_full, f_empty, f_af, f_ae, f_ov, f_uf;
   logic [3:0]  s_count, f_count;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   sync_fifo_flags #(.DEPTH(8), .WIDTH(64), .MODE(FIFO_STD)) u_std (
      .clk(clk), .reset(reset), .wen(s_wen), .din(s_din), .ren(s_ren), .clr_err(clr_err),
      .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .count(s_count), .overflow(s_ov), .underflow(s_uf));
   sync_fifo_flags #(.DEPTH(8), .WIDTH(64), .MODE(FIFO_FWFT)) u_fwft (
      .clk(clk), .reset(reset), .wen(f_wen), .din(f_din), .ren(f_ren), .clr_err(clr_err),
      .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .overflow(f_ov), .underflow(f_uf));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      #1 reset = 0;
      #1;
      checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", s_count); end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", s_empty); end
      checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", s_full); end
      checks++; if (s_ae !== 1'b1) begin errors++; $display("FAIL rst_almost_empty: got %b expected 1", s_ae); end
      checks++; if (s_af !== 1'b0) begin errors++; $display("FAIL rst_almost_full: got %b expected 0", s_af); end
      checks++; if (s_dout !== 64'h0) begin errors++; $display("FAIL rst_dout: got %h expected 0", s_dout); end
      checks++; if (s_ov !== 1'b0 || s_uf !== 1'b0) begin errors++; $display("FAIL rst_err: got ov=%b uf=%b expected 0 0", s_ov, s_uf); end
      checks++; if (f_empty !== 1'b1 || f_dout !== 64'h0) begin errors++; $display("FAIL rst_fwft: got empty=%b dout=%h expected 1 0", f_empty, f_dout); end
      tick;
      tick;
      reset = 1;
      tick;
   endtask
   task automatic test_fill;
      for (int i = 0; i < 8; i++) begin
         s_wen = 1; s_din = 64'(i);
         tick;
         checks++; if (s_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, s_count, i + 1); end
         checks++; if (s_af !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, s_af, i + 1 >= 6); end
      end
      checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", s_full); end
      checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL fill_no_ov: got %b expected 0", s_ov); end
      s_din = 64'h99;
      tick;
      s_wen = 0;
      checks++; if (s_ov !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", s_ov); end
      checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", s_count); end
`ifdef SYNC_FIFO_ERR_STICKY_EN
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (s_ov !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d]: got %b expected 1", i, s_ov); end
      end
      s_wen = 1; clr_err = 1;
      tick;
      s_wen = 0; clr_err = 0;
      checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL ovf_clr_prio: got %b expected 0", s_ov); end
`else
      tick;
      checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b expected 0", s_ov); end
`endif
   endtask
   task automatic test_drain;
      for (int i = 0; i < 8; i++) begin
         s_ren = 1;
         tick;
         checks++; if (s_dout !== 64'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, s_dout, i); end
         checks++; if (s_count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, s_count, 7 - i); end
         checks++; if (s_ae !== (7 - i <= 1)) begin errors++; $display("FAIL drain_ae[%0d]: got %b expected %b", i, s_ae, 7 - i <= 1); end
      end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", s_empty); end
      checks++; if (s_uf !== 1'b0) begin errors++; $display("FAIL drain_no_uf: got %b expected 0", s_uf); end
      tick;
      s_ren = 0;
      checks++; if (s_uf !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", s_uf); end
      checks++; if (s_dout !== 64'h7) begin errors++; $display("FAIL udf_dout_hold: got %h expected 7", s_dout); end
`ifdef SYNC_FIFO_ERR_STICKY_EN
      tick;
      checks++; if (s_uf !== 1'b1) begin errors++; $display("FAIL udf_sticky: got %b expected 1", s_uf); end
      clr_err = 1;
      tick;
      clr_err = 0;
      checks++; if (s_uf !== 1'b0) begin errors++; $display("FAIL udf_clr: got %b expected 0", s_uf); end
`else
      tick;
      checks++; if (s_uf !== 1'b0) begin errors++; $display("FAIL udf_pulse_end: got %b expected 0", s_uf); end
`endif
   endtask
   task automatic test_fwft;
      f_wen = 1; f_din = 64'hA5;
      tick;
      f_wen = 0;
      checks++; if (f_dout !== 64'hA5) begin errors++; $display("FAIL fwft_show: got %h expected a5", f_dout); end
      tick;
      checks++; if (f_dout !== 64'hA5 || f_count !== 4'd1) begin errors++; $display("FAIL fwft_hold: got dout=%h count=%0d expected a5 1", f_dout, f_count); end
      f_ren = 1;
      tick;
      f_ren = 0;
      checks++; if (f_empty !== 1'b1 || f_dout !== 64'h0) begin errors++; $display("FAIL fwft_pop: got empty=%b dout=%h expected 1 0", f_empty, f_dout); end
      f_wen = 1; f_din = 64'h11;
      tick;
      f_din = 64'h22;
      tick;
      f_wen = 0; f_ren = 1;
      checks++; if (f_dout !== 64'h11) begin errors++; $display("FAIL fwft_head1: got %h expected 11", f_dout); end
      tick;
      checks++; if (f_dout !== 64'h22) begin errors++; $display("FAIL fwft_head2: got %h expected 22", f_dout); end
      tick;
      f_ren = 0;
      checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty: got %b expected 1", f_empty); end
   endtask
   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) begin
         s_wen = 1; s_din = 64'h10 + 64'(i);
         tick;
      end
      s_din = 64'hFF; s_ren = 1;
      tick;
      s_wen = 0;
      checks++; if (s_count !== 4'd7) begin errors++; $display("FAIL b2b_full_count: got %0d expected 7", s_count); end
      checks++; if (s_dout !== 64'h10) begin errors++; $display("FAIL b2b_full_dout: got %h expected 10", s_dout); end
      for (int i = 0; i < 7; i++) begin
         tick;
         checks++; if (s_dout !== 64'h11 + 64'(i)) begin errors++; $display("FAIL b2b_drain[%0d]: got %h expected %h", i, s_dout, 64'h11 + 64'(i)); end
      end
      s_ren = 0;
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL b2b_no_ff: got empty=%b expected 1", s_empty); end
      s_wen = 1; s_ren = 1; s_din = 64'h42;
      tick;
      s_wen = 0; s_ren = 0;
      checks++; if (s_count !== 4'd1) begin errors++; $display("FAIL b2b_empty_count: got %0d expected 1", s_count); end
      checks++; if (s_dout !== 64'h17) begin errors++; $display("FAIL b2b_empty_dout_hold: got %h expected 17", s_dout); end
      clr_err = 1;
      tick;
      clr_err = 0; s_ren = 1;
      tick;
      s_ren = 0;
      checks++; if (s_dout !== 64'h42 || s_count !== 4'd0) begin errors++; $display("FAIL b2b_pass: got dout=%h count=%0d expected 42 0", s_dout, s_count); end
   endtask
   task automatic test_wrap;
      int max_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         s_wen = 1; s_din = 64'h100 + 64'(k);
         tick;
         s_wen = 0; s_ren = 1;
         if (int'(s_count) > max_cnt) max_cnt = int'(s_count);
         checks++; if (s_count !== 4'd1) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected 1", k, s_count); end
         tick;
         s_ren = 0;
         checks++; if (s_dout !== 64'h100 + 64'(k)) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, s_dout, 64'h100 + 64'(k)); end
      end
      checks++; if (max_cnt > 2) begin errors++; $display("FAIL wrap_max: got %0d expected <=2", max_cnt); end
   endtask
   task automatic test_async_reset;
      for (int i = 0; i < 9; i++) begin
         s_wen = 1; s_din = 64'h200 + 64'(i);
         f_wen = 1; f_din = 64'h300 + 64'(i);
         tick;
      end
      checks++; if (s_ov !== 1'b1 || s_count !== 4'd8) begin errors++; $display("FAIL arst_pre: got ov=%b count=%0d expected 1 8", s_ov, s_count); end
      #2 reset = 0;
      #1;
      checks++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin errors++; $display("FAIL arst_std: got count=%0d empty=%b full=%b expected 0 1 0", s_count, s_empty, s_full); end
      checks++; if (s_ae !== 1'b1 || s_af !== 1'b0 || s_ov !== 1'b0 || s_uf !== 1'b0) begin errors++; $display("FAIL arst_flags: got ae=%b af=%b ov=%b uf=%b expected 1 0 0 0", s_ae, s_af, s_ov, s_uf); end
      checks++; if (s_dout !== 64'h0) begin errors++; $display("FAIL arst_dout: got %h expected 0", s_dout); end
      checks++; if (f_count !== 4'd0 || f_dout !== 64'h0) begin errors++; $display("FAIL arst_fwft: got count=%0d dout=%h expected 0 0", f_count, f_dout); end
      s_wen = 0; f_wen = 0;
      tick;
      reset = 1;
      tick;
      checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL arst_after: got %0d expected 0", s_count); end
   endtask
   initial begin
      test_reset;
      test_fill;
      test_drain;
      test_fwft;
      test_back_to_back;
      test_wrap;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
